// File: rtl/fx_limiter_pkg.sv
// fx_pkg: shared constants and types for the stereo peak limiter
package fx_pkg;
    localparam int GAIN_W = 16;
    localparam logic [GAIN_W-1:0] UNITY_GAIN = 16'h8000;
    localparam int SAMPLE_W = 16;
    typedef enum logic [1:0] {S_IDLE, S_DIV, S_UPDATE, S_APPLY} fx_lim_state_t;
    typedef logic signed [SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/fx_limiter_if.sv
// fx_limiter_if: stereo audio and control bundle; gr_level exists only with FX_LIMITER_METER_EN
interface fx_limiter_if #(
    parameter int DATA_W = 16,
    parameter int PARAM_W = 7
);
    logic [1:0][DATA_W-1:0] audio_in;
    logic [1:0][DATA_W-1:0] audio_out;
    logic [PARAM_W-1:0] fx_threshold;
    logic [PARAM_W-1:0] fx_release;
    logic sample_en;
`ifdef FX_LIMITER_METER_EN
    logic [7:0] gr_level;
    modport master (output audio_in, fx_threshold, fx_release, sample_en, input audio_out, gr_level);
    modport slave (input audio_in, fx_threshold, fx_release, sample_en, output audio_out, gr_level);
`else
    modport master (output audio_in, fx_threshold, fx_release, sample_en, input audio_out);
    modport slave (input audio_in, fx_threshold, fx_release, sample_en, output audio_out);
`endif
endinterface

// File: rtl/fx_limiter_div.sv
// fx_limiter_div: restoring unsigned divider, one quotient bit per cycle (QW cycles)
module fx_limiter_div #(
    parameter int DW = 16,
    parameter int QW = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [DW+QW-2:0] dividend,
    input  logic [DW-1:0]    divisor,
    output logic             busy,
    output logic             done,
    output logic [QW-1:0]    quotient
);
    localparam int CW = $clog2(QW + 1);
    logic [DW-1:0] rem;
    logic [DW:0] rem_sh;
    logic [DW-1:0] d_q;
    logic [QW-1:0] q;
    logic [CW-1:0] cnt;
    logic ge;
    // The upper dividend bits seed the remainder; valid only when they are below the divisor,
    // which holds whenever the quotient is actually used (peak > thr)
    assign rem_sh = {rem, q[QW-1]};
    assign ge = rem_sh >= {1'b0, d_q};
    assign busy = cnt != '0;
    assign done = cnt == CW'(1);
    assign quotient = q;
    // q doubles as the dividend shifter: dividend bits leave at the top, quotient bits enter at the bottom
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem <= '0;
            d_q <= '0;
            q <= '0;
            cnt <= '0;
        end else if (start) begin
            rem <= {1'b0, dividend[DW+QW-2:QW]};
            d_q <= divisor;
            q <= dividend[QW-1:0];
            cnt <= CW'(QW);
        end else if (busy) begin
            rem <= ge ? DW'(rem_sh - {1'b0, d_q}) : rem_sh[DW-1:0];
            q <= {q[QW-2:0], ge};
            cnt <= cnt - CW'(1);
        end
    end
endmodule

// File: rtl/fx_limiter.sv
// fx_limiter: stereo peak limiter, instant attack / hold / exponential release; meter via FX_LIMITER_METER_EN
module fx_limiter
    import fx_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int PARAM_W = 7,
    parameter int HOLD_SAMPLES = 480
) (
    input logic clk,
    input logic reset_n,
    fx_limiter_if.slave bus
);
    localparam int HW = $clog2(HOLD_SAMPLES + 1);
    localparam int P = DATA_W + GAIN_W;
    localparam logic signed [P:0] S_MAX = (P+1)'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [P:0] S_MIN = -S_MAX - 1;
    fx_lim_state_t state, state_nxt;
    logic [1:0][DATA_W-1:0] x_q, out_q, sat;
    logic [DATA_W-1:0] abs_l, abs_r, peak_in, thr_in, peak_q, thr_q;
    logic [2:0] rel_q;
    logic [GAIN_W-1:0] g, quo, target, g_rel;
    logic [GAIN_W:0] g_step;
    logic [HW-1:0] hold_cnt;
    logic start, div_busy, div_done;
    assign abs_l = bus.audio_in[0][DATA_W-1] ? -bus.audio_in[0] : bus.audio_in[0];
    assign abs_r = bus.audio_in[1][DATA_W-1] ? -bus.audio_in[1] : bus.audio_in[1];
    assign peak_in = abs_l > abs_r ? abs_l : abs_r;
    assign thr_in = {(PARAM_W+1)'(bus.fx_threshold) + (PARAM_W+1)'(1), {(DATA_W-1-PARAM_W){1'b0}}};
    assign start = (state == S_IDLE) && bus.sample_en && !div_busy;
    assign target = (peak_q == '0 || peak_q <= thr_q) ? UNITY_GAIN : quo;
    assign g_step = {1'b0, g} + {1'b0, (UNITY_GAIN - g) >> (4'd4 + {1'b0, rel_q})} + (GAIN_W+1)'(1);
    assign g_rel = (g_step > {1'b0, target}) ? target : g_step[GAIN_W-1:0];
    assign bus.audio_out = out_q;

    fx_limiter_div #(.DW(DATA_W), .QW(GAIN_W)) u_div (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .dividend({thr_in, {(GAIN_W-1){1'b0}}}),
        .divisor(peak_in),
        .busy(div_busy),
        .done(div_done),
        .quotient(quo)
    );

    for (genvar i = 0; i < 2; i++) begin : g_ch
        logic signed [P:0] prod, shr;
        assign prod = (P+1)'($signed(x_q[i])) * (P+1)'($signed({1'b0, g}));
        assign shr = prod >>> (GAIN_W - 1);
        assign sat[i] = shr > S_MAX ? S_MAX[DATA_W-1:0] : shr < S_MIN ? S_MIN[DATA_W-1:0] : shr[DATA_W-1:0];
    end

    // State register; async reset aborts any sample in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else state <= state_nxt;
    end

    // Fixed sequence: divide for GAIN_W cycles, then one update and one apply cycle
    always_comb begin
        state_nxt = state;
        state_nxt = state == S_IDLE ? (start ? S_DIV : S_IDLE) :
                    state == S_DIV ? (div_done ? S_UPDATE : S_DIV) :
                    state == S_UPDATE ? S_APPLY : S_IDLE;
    end

    // Capture the sample, update gain/hold, then apply the fresh gain to the same sample
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q <= '0;
            peak_q <= '0;
            thr_q <= '0;
            rel_q <= '0;
            g <= UNITY_GAIN;
            hold_cnt <= '0;
            out_q <= '0;
        end else begin
            if (start) begin
                x_q <= bus.audio_in;
                peak_q <= peak_in;
                thr_q <= thr_in;
                rel_q <= bus.fx_release[PARAM_W-1:PARAM_W-3];
            end
            if (state == S_UPDATE) begin
                if (target < g) begin
                    g <= target;
                    hold_cnt <= HW'(HOLD_SAMPLES);
                end else if (hold_cnt != '0) begin
                    hold_cnt <= hold_cnt - HW'(1);
                end else begin
                    g <= g_rel;
                end
            end
            if (state == S_APPLY) out_q <= sat;
        end
    end

`ifdef FX_LIMITER_METER_EN
    logic [7:0] gr_q;
    // Meter follows the gain applied to the sample just output
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) gr_q <= '0;
        else if (state == S_APPLY) gr_q <= 8'((UNITY_GAIN - g) >> 7);
    end
    assign bus.gr_level = gr_q;
`endif
endmodule

// File: tb/tb_fx_limiter.sv
// tb_fx_limiter: directed vectors and multi-cycle sequences for fx_limiter
module tb_fx_limiter;
    import fx_pkg::*;
    typedef struct {
        int l;
        int r;
        int th;
        int el;
        int er;
        int eg;
        string nm;
    } vec_t;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int errs = 0;
    int checks = 0;
    int last_l = 0;
    int last_r = 0;
    int gm;
    int n;
    vec_t v[9];
    sample_t o_l, o_r;

    fx_limiter_if #(.DATA_W(16), .PARAM_W(7)) bus ();
    fx_limiter #(.DATA_W(16), .PARAM_W(7), .HOLD_SAMPLES(480)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    assign o_l = bus.audio_out[0];
    assign o_r = bus.audio_out[1];
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic signed [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_out(input string nm, input int el, input int er, input int eg);
        chk({nm, "_l"}, o_l, el);
        chk({nm, "_r"}, o_r, er);
`ifdef FX_LIMITER_METER_EN
        chk({nm, "_gr"}, {24'd0, bus.gr_level}, (32768 - eg) >> 7);
`endif
        last_l = el;
        last_r = er;
    endtask

    task automatic strobe(input int l, input int r, input int th, input int rel);
        @(negedge clk);
        bus.audio_in[0] = 16'(l);
        bus.audio_in[1] = 16'(r);
        bus.fx_threshold = 7'(th);
        bus.fx_release = 7'(rel);
        bus.sample_en = 1'b1;
        @(negedge clk);
        bus.sample_en = 1'b0;
    endtask

    task automatic run(input int l, input int r, input int th, input int rel,
                       input int el, input int er, input int eg, input string nm);
        strobe(l, r, th, rel);
        repeat (17) @(negedge clk);
        chk({nm, "_c18_l"}, o_l, last_l);
        chk({nm, "_c18_r"}, o_r, last_r);
        @(negedge clk);
        check_out(nm, el, er, eg);
    endtask

    initial begin
        v[0] = '{20000, -20000, 127, 20000, -20000, 32768, "thr127"};
        v[1] = '{-32768, 32767, 127, -32768, 32767, 32768, "thr127_full"};
        v[2] = '{32767, 0, 63, 16383, 0, 16384, "thr63_pos"};
        v[3] = '{-32768, 100, 63, -16384, 50, 16384, "thr63_neg"};
        v[4] = '{0, -16384, 31, 0, -8192, 16384, "thr31_eq"};
        v[5] = '{0, -32768, 31, 0, -8192, 8192, "thr31_cut"};
        v[6] = '{12345, -1, 127, 3086, -1, 8192, "hold_low"};
        v[7] = '{1000, -999, 0, 250, -250, 8192, "thr0_mid"};
        v[8] = '{32767, -32768, 0, 255, -256, 256, "thr0_full"};
        bus.audio_in = '0;
        bus.fx_threshold = '0;
        bus.fx_release = '0;
        bus.sample_en = 1'b0;
        repeat (3) @(negedge clk);
        check_out("reset", 0, 0, 32768);
        reset_n = 1'b1;
        foreach (v[i]) run(v[i].l, v[i].r, v[i].th, 0, v[i].el, v[i].er, v[i].eg, v[i].nm);
        // reset while the divider is running
        strobe(30000, -30000, 127, 0);
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_out("rst_mid", 0, 0, 32768);
        @(negedge clk);
        reset_n = 1'b1;
        // normal sample after reset, with a stray strobe at cycle 5
        strobe(30000, -30000, 127, 0);
        repeat (3) @(negedge clk);
        @(negedge clk);
        bus.audio_in[0] = 16'd111;
        bus.audio_in[1] = 16'd222;
        bus.sample_en = 1'b1;
        @(negedge clk);
        bus.sample_en = 1'b0;
        repeat (12) @(negedge clk);
        check_out("dbl_c18", 0, 0, 32768);
        @(negedge clk);
        check_out("dbl_c19", 30000, -30000, 32768);
        repeat (8) @(negedge clk);
        check_out("dbl_keep", 30000, -30000, 32768);
        // hold then fast release
        run(32767, 0, 63, 0, 16383, 0, 16384, "lim_set");
        for (int i = 0; i < 480; i++) run(1000, 0, 63, 0, 500, 0, 16384, "lim_hold");
        run(1000, 0, 63, 0, 531, 0, 17409, "rel_first");
        gm = 17409;
        n = 0;
        while (gm < 32768 && n < 400) begin
            gm = gm + ((32768 - gm) >> 4) + 1;
            if (gm > 32768) gm = 32768;
            run(1000, 0, 63, 0, (1000 * gm) >> 15, 0, gm, "rel_ramp");
            n++;
        end
        chk("rel_steps_bounded", {31'd0, n < 400}, 1);
        run(1000, 0, 63, 0, 1000, 0, 32768, "rel_done");
        // slowest release speed (shift 11)
        run(32767, 0, 63, 7'h70, 16383, 0, 16384, "lim_set2");
        for (int i = 0; i < 480; i++) run(16000, 0, 63, 7'h70, 8000, 0, 16384, "lim_hold2");
        run(16000, 0, 63, 7'h70, 8004, 0, 16393, "rel_slow1");
        run(16000, 0, 63, 7'h70, 8008, 0, 16401, "rel_slow2");
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
